// File: rtl/mul_sequencer_pkg.sv
// Shared ALU operation codes and multiply sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_NOR     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_BRANCH  = 4'b0100;
  localparam logic [3:0] ALU_INC     = 4'b0101;
  localparam logic [3:0] ALU_MUL     = 4'b0110;
  localparam logic [3:0] ALU_MOV     = 4'b0111;
  localparam logic [3:0] ALU_DEFAULT = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_sequencer_if.sv
// Execute-stage signals shared between the pipeline and the multiply sequencer.
interface mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic [3:0]       ALUOperation;
  logic             op_valid;
  logic             flush;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  modport master (
    output ALUOperation, op_valid, flush, A, B,
    input  stall, busy, result, result_valid
  );

  modport slave (
    input  ALUOperation, op_valid, flush, A, B,
    output stall, busy, result, result_valid
  );
endinterface

// File: rtl/mul_sequencer_datapath.sv
// Shift-add multiply datapath: multiplicand, multiplier and accumulator registers.
module mul_shift_add_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_next_o
);
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] addend;

  // Accumulator value after the current step; also used to capture the final product.
  always_comb begin
    addend     = mplier_q[0] ? mcand_q : '0;
    acc_next_o = acc_q + addend;
  end

  // Next-state selection: load clears the accumulator, step shifts and accumulates.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_next_o;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply controller: stalls the pipeline while the shift-add datapath runs.
import alu_pkg::*;

module mul_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [3:0]  MUL_OP = ALU_MUL
) (
  input  logic            clk,
  input  logic            reset,
  mul_sequencer_if.slave  bus
);
  localparam int unsigned     CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_next;
  logic             accept;
  logic             load;
  logic             step;

  assign accept = (state_q == IDLE) && bus.op_valid &&
                  (bus.ALUOperation == MUL_OP) && !bus.flush;

  mul_shift_add_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .step_i     (step),
    .mcand_i    (bus.A),
    .mplier_i   (bus.B),
    .acc_next_o (acc_next)
  );

  // State, iteration counter and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // Next state; the product is captured on the edge entering DONE so it is valid during DONE.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST) begin
            state_d  = DONE;
            result_d = acc_next;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath enables.
  always_comb begin
    load             = accept;
    step             = (state_q == RUN) && !bus.flush;
    bus.stall        = !reset && (accept || step);
    bus.busy         = (state_q != IDLE);
    bus.result_valid = (state_q == DONE) && !bus.flush;
    bus.result       = result_q;
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed scoreboard bench for mul_sequencer.
module tb_mul_sequencer;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W), .MUL_OP(4'b0110)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned     checks = 0;
  int unsigned     errors = 0;
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    last_result;
  logic [W-1:0]    mon_exp;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic valid, input logic fl,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.ALUOperation = op;
    bus.op_valid     = valid;
    bus.flush        = fl;
    bus.A            = a;
    bus.B            = b;
  endtask

  // Caller is positioned just after a rising edge; accept happens in this cycle (cycle 0).
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
    drive(ALU_MUL, 1'b1, 1'b0, a, b);
    exp_q.push_back(e);
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      if (c <= 32) begin
        chk("stall_run", W'(bus.stall), W'(1));
        chk("rv_low_run", W'(bus.result_valid), W'(0));
      end else begin
        chk("stall_done", W'(bus.stall), W'(0));
        chk("rv_done", W'(bus.result_valid), W'(1));
      end
      chk("busy", W'(bus.busy), (c == 0) ? W'(0) : W'(1));
      @(posedge clk);
      #1;
    end
    last_result = e;
  endtask

  // Monitor: every result_valid pulse must match the oldest expected product.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.result_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result_valid actual=1 required=0 result=%0h", bus.result);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("result", bus.result, mon_exp);
        end
      end
    end
  end

  initial begin
    last_result = '0;
    reset = 1'b1;
    drive(ALU_MUL, 1'b1, 1'b0, 32'd3, 32'd5);
    @(negedge clk);
    chk("reset_stall", W'(bus.stall), W'(0));
    chk("reset_busy", W'(bus.busy), W'(0));
    chk("reset_result", bus.result, W'(0));
    chk("reset_rv", W'(bus.result_valid), W'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(ALU_ADD, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;

    run_mul(32'd3, 32'd5, 32'd15);
    drive(ALU_ADD, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;

    // Flush in cycle 10 of a 7*9 multiply.
    drive(ALU_MUL, 1'b1, 1'b0, 32'd7, 32'd9);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("flush_pre_stall", W'(bus.stall), W'(1));
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", W'(bus.stall), W'(0));
    chk("flush_rv", W'(bus.result_valid), W'(0));
    @(posedge clk);
    #1;
    drive(ALU_ADD, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("flush_busy", W'(bus.busy), W'(0));
      chk("flush_rv_after", W'(bus.result_valid), W'(0));
      chk("flush_result_held", bus.result, last_result);
      @(posedge clk);
      #1;
    end

    run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);

    // Non-MUL operation passes through.
    drive(ALU_ADD, 1'b1, 1'b0, 32'd12, 32'd34);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("add_stall", W'(bus.stall), W'(0));
      chk("add_busy", W'(bus.busy), W'(0));
      chk("add_rv", W'(bus.result_valid), W'(0));
      chk("add_result_held", bus.result, last_result);
      @(posedge clk);
      #1;
    end

    run_mul(32'h0001_0000, 32'h0001_0000, 32'h0);
    drive(ALU_ADD, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    run_mul(32'd5, 32'd6, 32'd30);

    // Asynchronous reset in cycle 15 of a 9*11 multiply.
    drive(ALU_MUL, 1'b1, 1'b0, 32'd9, 32'd11);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("rst_pre_busy", W'(bus.busy), (c == 0) ? W'(0) : W'(1));
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_stall", W'(bus.stall), W'(0));
    chk("async_rst_busy", W'(bus.busy), W'(0));
    chk("async_rst_result", bus.result, W'(0));
    chk("async_rst_rv", W'(bus.result_valid), W'(0));
    last_result = '0;
    drive(ALU_ADD, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_mul(32'd6, 32'd7, 32'd42);
    run_mul(32'd4, 32'd4, 32'd16);
    run_mul(32'd10, 32'd10, 32'd100);
    drive(ALU_ADD, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("final_result_held", bus.result, last_result);
      @(posedge clk);
      #1;
    end
    chk("scoreboard_drained", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Multi-cycle controller and datapath for the ALU multiply operation (ALUOperation code 4'b0110). It sits beside the ALU in the execute stage. When the ALU control decodes MUL, this block takes over, runs an iterative shift-add multiply, and stalls the PC and pipeline registers until the product is ready. All other ALU operations pass through untouched, with no stall.

Parameters:
WIDTH, 32, operand and result width in bits.
MUL_OP, 4'b0110, ALUOperation code that triggers a multiply.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
ALUOperation  input  4  operation code from the ALU control unit.
op_valid  input  1  a valid instruction is present in the execute stage.
flush  input  1  kill the in-flight instruction (branch/jump squash).
A  input  WIDTH  multiplicand (rs value).
B  input  WIDTH  multiplier (rt value).
stall  output  1  hold PC and pipeline registers; combinational.
busy  output  1  FSM is not in IDLE; registered.
result  output  WIDTH  low WIDTH bits of A*B; registered, held until the next accept.
result_valid  output  1  one-cycle pulse; result is valid for writeback.

Behaviour:
- One clock, clk. reset is asynchronous and active-high. Reset forces state=IDLE, count=0, accumulator=0, result=0, result_valid=0 and busy=0. stall evaluates to 0 while reset is asserted.
- Accept condition: state==IDLE && op_valid && ALUOperation==MUL_OP && !flush.
- States:
  - IDLE: on accept, latch mcand=A, mplier=B, acc=0, count=0, then go to RUN. stall=1 during the accept cycle (combinational). Otherwise stay in IDLE with stall=0.
  - RUN: every cycle:
    - if mplier[0] then acc <= acc + mcand;
    - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
    - When count==WIDTH-1, the final step is done and the state goes to DONE.
    - stall=1 throughout RUN.
  - DONE: result <= acc, registered at the DONE entry edge or equivalently during DONE. result_valid=1 and stall=0 so the stalled instruction advances at the end of this cycle. Next state is unconditionally IDLE. A MUL request seen during DONE is the same instruction and is ignored.
- Latency:
  - Accept in cycle 0; RUN occupies cycles 1..WIDTH; DONE is cycle WIDTH+1.
  - result_valid is high in cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - Latency is fixed; there is no early termination on mplier==0.
- Arithmetic:
  - The product is taken modulo 2^WIDTH; overflow is silently discarded.
  - The low half is identical for signed and unsigned operands, so there is no sign handling.
  - acc, mcand and mplier are all WIDTH bits wide.
- count width: $clog2(WIDTH)+1; it never wraps inside a single operation.
- flush:
  - In RUN: go to IDLE next cycle with no result_valid; result keeps its old value; stall is deasserted in that same cycle.
  - In IDLE: flush suppresses accept.
  - In DONE: flush also suppresses result_valid; the state still returns to IDLE.
- Non-MUL ALUOperation values: no state change, stall=0, result unchanged.
- busy = (state != IDLE).
- Reset mid-operation: immediate return to IDLE; no result_valid is produced.
- Unused state encodings go to IDLE.

Decomposition:
- Shared package, alu_pkg:
  - ALU operation codes: AND 4'b0000, OR 4'b0001, NOR 4'b0010, ADD 4'b0011, BRANCH 4'b0100, INC 4'b0101, MUL 4'b0110, MOV 4'b0111, DEFAULT 4'b1001.
  - The mul_sequencer state enumeration: IDLE, RUN, DONE.
- One sub-module, mul_shift_add_datapath: the mcand/mplier/acc registers and adder, with load and step enables.
- The FSM and counter live in mul_sequencer.

Test Plan:
- A=3, B=5, MUL op, op_valid held (WIDTH=32) -> stall=1 in cycles 0..32; result=15 and result_valid=1 in cycle 33; stall=0 in cycle 33.
- A=32'hFFFFFFFF, B=2 -> result=32'hFFFFFFFE. A=32'h00010000, B=32'h00010000 -> result=0 (wrap).
- ALUOperation=4'b0011 (ADD) with op_valid=1 for 10 cycles -> stall=0, busy=0, result_valid never asserted.
- MUL 7*9 started; flush pulsed in cycle 10 -> cycle 11 IDLE, busy=0, result_valid never high, result holds its prior value.
- reset asserted asynchronously mid-RUN (cycle 15) -> outputs are zero immediately; after reset release, a MUL 6*7 gives result=42 at the 33rd cycle after accept.
- Back-to-back MULs 4*4 then 10*10 -> first result_valid with 16; IDLE; second accept on the next cycle; second result_valid with 100 exactly 33 cycles after its accept.
